pipe_adder: RTL and testbench
=============================

// Module: pipe_adder
// PURPOSE
//  Parametrised pipelined adder, successor to the 4-bit combinational full_adder.
//  Computes {cout,sum} = a + b + cin over WIDTH bits, split into STAGES carry-chained slices.
//  Uses a valid/ready stream on input and output, with full backpressure.
//  Sits between operand producers and the datapath where a single-cycle WIDTH-bit carry chain misses timing.
// PARAMETERS
//  WIDTH   32  operand/sum width; must be a multiple of STAGES
//  STAGES  4   pipeline depth = number of slices; each slice is SLICE = WIDTH/STAGES bits
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous active-high reset
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      adder accepts operands this cycle
//  a          in   WIDTH  operand A, unsigned (two's-complement if PIPE_ADDER_OVF_EN)
//  b          in   WIDTH  operand B
//  cin        in   1      carry in
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  sum        out  WIDTH  a+b+cin modulo 2^WIDTH
//  cout       out  1      carry out of bit WIDTH-1
//  ovf        out  1      signed overflow; present only with PIPE_ADDER_OVF_EN
// BEHAVIOUR
//  - Reset: all stage valid bits <= 0 and all data registers <= 0.
//    Outputs out_valid=0, sum=0, cout=0, ovf=0. in_ready=0 while rst=1.
//  - Global stall: adv = !out_valid | out_ready; in_ready = adv & !rst.
//    All stages shift only when adv=1, otherwise every register holds.
//  - Input handshake: a beat is taken when in_valid & in_ready.
//  - Output handshake: a result is consumed when out_valid & out_ready.
//    sum/cout/ovf are stable while out_valid & !out_ready.
//  - Stage k (0..STAGES-1) adds slice k of a and b plus the carry registered by stage k-1.
//    Stage 0 uses cin as its carry. Slices above k ride along in skew registers.
//    Lower result slices already computed ride along as well.
//  - Latency: a beat accepted in cycle N appears on out_valid in cycle N+STAGES when adv stays high.
//    Throughput is 1 beat/cycle. Bubbles (in_valid=0) propagate as valid=0 slots.
//  - Results leave in acceptance order. A beat is never duplicated or dropped unless rst is asserted.
//  - Width rule: internal slice add is SLICE+1 bits. The top bit is the carry to the next stage.
//    The final stage's carry drives cout.
//  - Boundaries:
//    - all-ones + all-ones + cin=1 -> sum=all-ones, cout=1.
//    - A carry generated in slice 0 must ripple through every later slice, one per stage (e.g. 0xFFFFFFFF+0+1).
//    - in_valid=1 while out_valid & !out_ready -> in_ready=0, beat not taken, pipeline frozen.
//    - A beat is taken and a result consumed in the same cycle -> both occur, no bubble.
//  - Reset mid-operation: in-flight beats are discarded. out_valid=0 in the cycle after rst.
//    in_ready=1 once rst deasserts.
//  - STAGES=1: single registered adder, latency 1.
// CONFIGURATION
//  - PIPE_ADDER_OVF_EN defined:
//    - Adds port ovf = (a[W-1]==b[W-1]) & (sum[W-1]!=a[W-1]).
//    - The operand sign bits are carried down the pipe so ovf is aligned with sum.
//    - Reset value of ovf is 0.
//  - Undefined: no ovf port and no sign-bit skew registers. Other behaviour is identical.
// TESTING (WIDTH=32, STAGES=4, out_ready=1 unless stated)
//  1. a=2, b=3, cin=0, one beat -> out_valid high exactly 4 cycles later with sum=5, cout=0.
//  2. a=0xFFFFFFFF, b=0, cin=1 -> sum=0, cout=1; checks the carry crossing all 3 slice boundaries.
//  3. 20 back-to-back random beats -> 20 results in order on consecutive cycles.
//     Each result {cout,sum} === a+b+cin (33-bit reference).
//  4. Stream beats and hold out_ready=0 for 5 cycles mid-stream:
//     - in_ready=0 whenever out_valid=1, and sum/cout hold.
//     - No loss or duplication after release.
//  5. Assert rst for 1 cycle with 3 beats in flight -> out_valid=0 next cycle, no stale result emerges.
//     A new beat 8+8 then yields 16.
//  6. With PIPE_ADDER_OVF_EN: 0x7FFFFFFF+1 -> ovf=1. 0x80000000+0x80000000 -> ovf=1, cout=1. 5+(-3) -> ovf=0.

Source files
------------

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit adder with valid/ready handshake, STAGES carry-chained slices.
// Define PIPE_ADDER_OVF_EN to add the signed-overflow output ovf.
module pipe_adder #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PIPE_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned SLICE = WIDTH / STAGES;

    if ((WIDTH % STAGES) != 0) begin : g_bad_width
        $error("pipe_adder: WIDTH must be a multiple of STAGES");
    end

    // Per-stage registers: operands (upper slices still pending), partial sum, carry, valid
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic             c_q [STAGES];
    logic             v_q [STAGES];

    // Stage inputs: ports for stage 0, previous stage's registers otherwise
    logic [WIDTH-1:0] a_i [STAGES];
    logic [WIDTH-1:0] b_i [STAGES];
    logic [WIDTH-1:0] s_i [STAGES];
    logic             c_i [STAGES];
    logic             v_i [STAGES];

    logic [WIDTH-1:0] s_d  [STAGES];
    logic [SLICE:0]   part [STAGES];
    logic             adv;

    assign a_i[0] = a;
    assign b_i[0] = b;
    assign s_i[0] = '0;
    assign c_i[0] = cin;
    assign v_i[0] = in_valid;

    for (genvar k = 1; k < STAGES; k++) begin : g_link
        assign a_i[k] = a_q[k-1];
        assign b_i[k] = b_q[k-1];
        assign s_i[k] = s_q[k-1];
        assign c_i[k] = c_q[k-1];
        assign v_i[k] = v_q[k-1];
    end

    // Whole pipe advances together; stalls only when the head result is not taken
    assign adv      = !v_q[STAGES-1] || out_ready;
    assign in_ready = adv && !rst;

    // Slice k add: SLICE+1 bits, top bit is the carry handed to stage k+1
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            part[k] = {1'b0, a_i[k][k*SLICE +: SLICE]}
                    + {1'b0, b_i[k][k*SLICE +: SLICE]}
                    + (SLICE+1)'(c_i[k]);
            s_d[k] = s_i[k];
            s_d[k][k*SLICE +: SLICE] = part[k][SLICE-1:0];
        end
    end

`ifdef PIPE_ADDER_OVF_EN
    logic ovf_d;
    logic ovf_q;

    // Operand sign bits reach the last stage inside the skewed operand slices
    assign ovf_d = (a_i[STAGES-1][WIDTH-1] == b_i[STAGES-1][WIDTH-1])
                 && (s_d[STAGES-1][WIDTH-1] != a_i[STAGES-1][WIDTH-1]);
    assign ovf   = ovf_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
                v_q[k] <= 1'b0;
            end
`ifdef PIPE_ADDER_OVF_EN
            ovf_q <= 1'b0;
`endif
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_i[k];
                b_q[k] <= b_i[k];
                s_q[k] <= s_d[k];
                c_q[k] <= part[k][SLICE];
                v_q[k] <= v_i[k];
            end
`ifdef PIPE_ADDER_OVF_EN
            ovf_q <= ovf_d;
`endif
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign cout      = c_q[STAGES-1];

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder (WIDTH=32, STAGES=4): queue-based reference model
// checked every cycle, plus directed vectors with literal expectations.
module tb_pipe_adder;

    localparam int unsigned W = 32;
    localparam int unsigned S = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
`ifdef PIPE_ADDER_OVF_EN
    logic         ovf;
`endif

    pipe_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef PIPE_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W:0] val;
        logic       ovf;
    } exp_t;

    int   checks   = 0;
    int   failures = 0;
    int   n_in     = 0;
    int   n_out    = 0;
    bit   started  = 1'b0;
    exp_t q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain 33-bit addition and true signed range test
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        exp_t   e;
        longint s;
        e.val = {1'b0, x} + {1'b0, y} + (W+1)'(c);
        s     = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        return e;
    endfunction

    // Per-cycle compare: handshake rule, stall stability, in-order results
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_sum;
    logic         prev_cout;
    always @(negedge clk) begin
        if (started) begin
            exp_t e;
            check("in_ready_rule", 64'(in_ready), 64'(!rst && (!out_valid || out_ready)));
            if (prev_stall) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_sum", 64'(sum), 64'(prev_sum));
                check("stall_cout", 64'(cout), 64'(prev_cout));
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (q.size() == 0) begin
                    check("unexpected_result", 64'(out_valid), 64'd0);
                end else begin
                    e = q.pop_front();
                    check("model_result", 64'({cout, sum}), 64'(e.val));
`ifdef PIPE_ADDER_OVF_EN
                    check("model_ovf", 64'(ovf), 64'(e.ovf));
`endif
                end
            end
            if (in_valid && in_ready) begin
                n_in++;
                q.push_back(model(a, b, cin));
            end
            if (rst) q.delete();
            prev_stall = out_valid && !out_ready && !rst;
            prev_sum   = sum;
            prev_cout  = cout;
        end
    end

    // Present one beat and hold it until taken; returns just after the accepting edge
    task automatic push(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        bit taken = 1'b0;
        in_valid = 1'b1;
        a        = x;
        b        = y;
        cin      = c;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (in_ready) begin
                taken = 1'b1;
                break;
            end
        end
        if (!taken) check("push_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out();
        bit seen = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("out_timeout", 64'd0, 64'd1);
    endtask

    task automatic single(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                          input logic [W-1:0] es, input logic ec, input logic eo);
        push(x, y, c);
        in_valid = 1'b0;
        wait_out();
        check("lit_sum", 64'(sum), 64'(es));
        check("lit_cout", 64'(cout), 64'(ec));
`ifdef PIPE_ADDER_OVF_EN
        check("lit_ovf", 64'(ovf), 64'(eo));
`else
        if (eo === 1'bx) check("lit_ovf_arg", 64'(eo), 64'd0);
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int t = 0; t < 60 && (q.size() != 0 || out_valid); t++) @(negedge clk);
        check("drain_empty", 64'(q.size()), 64'd0);
        check("no_loss_dup", 64'(n_out), 64'(n_in));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt;
        int n;
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
`ifdef PIPE_ADDER_OVF_EN
        check("rst_ovf", 64'(ovf), 64'd0);
`endif
        @(posedge clk);
        #1;
        rst     = 1'b0;
        started = 1'b1;

        // Latency of a single beat, counted from its accepting edge
        push(32'd2, 32'd3, 1'b0);
        in_valid = 1'b0;
        cnt = 1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            cnt++;
        end
        check("latency", 64'(cnt), 64'(S));
        check("lat_sum", 64'(sum), 64'd5);
        check("lat_cout", 64'(cout), 64'd0);
        @(posedge clk);
        #1;

        // Carry rippling through every slice boundary, and all-ones corner
        single(32'hFFFF_FFFF, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0);
        single(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        single(32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0);
        single(32'h7FFF_FFFF, 32'h1, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        single(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0, 1'b1, 1'b1);
        single(32'd5, 32'hFFFF_FFFD, 1'b0, 32'd2, 1'b1, 1'b0);
        drain();

        // 20 back-to-back beats must emerge on 20 consecutive cycles
        fork
            begin
                for (int i = 0; i < 20; i++) push($urandom, $urandom, 1'($urandom));
                in_valid = 1'b0;
            end
            begin
                wait_out();
                n = 0;
                while (out_valid && n < 40) begin
                    n++;
                    @(negedge clk);
                end
                check("consecutive", 64'(n), 64'd20);
            end
        join
        drain();

        // Backpressure mid-stream: 5 cycles with out_ready low
        fork
            begin
                for (int i = 0; i < 12; i++) push($urandom, $urandom, 1'($urandom));
                in_valid = 1'b0;
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with three beats in flight
        push(32'd1, 32'd1, 1'b0);
        push(32'd2, 32'd2, 1'b0);
        push(32'd3, 32'd3, 1'b0);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_valid", 64'(out_valid), 64'd0);
        check("post_rst_ready", 64'(in_ready), 64'd1);
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        check("no_stale", 64'(n), 64'd0);
        @(posedge clk);
        #1;
        n_in  = 0;
        n_out = 0;
        single(32'd8, 32'd8, 1'b0, 32'd16, 1'b0, 1'b0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
